// File: rtl/gauss3x3_stream_pkg.sv
// gauss3x3_stream_pkg: shared widths, kernel weights, FSM encodings and arithmetic helpers.
// FILTER_ROUND_EN selects round-half-up instead of truncation in scale().
package gauss3x3_stream_pkg;
   localparam int PIXEL_WIDTH = 8;
   localparam int DATA_WIDTH  = 32;
   localparam int MAX_WIDTH   = 1024;
   localparam int ADDR_WIDTH  = $clog2(MAX_WIDTH);
   localparam int SUM_WIDTH   = 12;
   localparam logic [3:0] K00 = 4'd1, K01 = 4'd2, K02 = 4'd1;
   localparam logic [3:0] K10 = 4'd2, K11 = 4'd4, K12 = 4'd2;
   localparam logic [3:0] K20 = 4'd1, K21 = 4'd2, K22 = 4'd1;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [PIXEL_WIDTH-1:0] DATA_TAG     = 8'hA5;
   localparam logic [PIXEL_WIDTH-1:0] DATA_END_TAG = 8'h5A;
   typedef struct packed {
      logic                   vld;
      logic                   brd;
      logic [PIXEL_WIDTH-1:0] ctr;
      logic [SUM_WIDTH-1:0]   sum;
   } stage_t;
   function automatic logic [SUM_WIDTH-1:0] tap(input logic [3:0] k, input logic [PIXEL_WIDTH-1:0] p);
      return SUM_WIDTH'(k) * SUM_WIDTH'(p);
   endfunction
   function automatic logic [PIXEL_WIDTH-1:0] scale(input logic [SUM_WIDTH-1:0] s);
      logic [SUM_WIDTH-1:0] t;
`ifdef FILTER_ROUND_EN
      t = s + SUM_WIDTH'(8);
`else
      t = s;
`endif
      return t[SUM_WIDTH-1:4];
   endfunction
endpackage

// File: rtl/gauss3x3_stream_if.sv
// gauss3x3_stream_if: frame control and pixel stream bundle between controller and filter.
interface gauss3x3_stream_if;
   import gauss3x3_stream_pkg::*;
   logic                   reflesh;
   logic [DATA_WIDTH-1:0]  image_width;
   logic [DATA_WIDTH-1:0]  image_size;
   logic [PIXEL_WIDTH:0]   data_in;
   logic [PIXEL_WIDTH:0]   data_out;
   logic                   busy;
   logic                   done;
   modport master (output reflesh, image_width, image_size, data_in, input data_out, busy, done);
   modport slave  (input reflesh, image_width, image_size, data_in, output data_out, busy, done);
endinterface

// File: rtl/gauss3x3_stream_line_buffer.sv
// gauss3x3_stream_line_buffer: circular delay RAM of runtime length i_len with registered read.
module gauss3x3_stream_line_buffer
   import gauss3x3_stream_pkg::*;
(
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic [ADDR_WIDTH:0]    i_len,
   input  logic [PIXEL_WIDTH-1:0] i_din,
   output logic [PIXEL_WIDTH-1:0] o_dout
);
   logic [PIXEL_WIDTH-1:0] r_mem [MAX_WIDTH];
   logic [ADDR_WIDTH-1:0]  r_ptr;
   logic [PIXEL_WIDTH-1:0] r_dout;
   logic                   w_wrap;
   assign w_wrap = {1'b0, r_ptr} == i_len - 1'b1;
   assign o_dout = r_dout;
   always_ff @(posedge i_clock)
      if (i_en) r_mem[r_ptr] <= i_din;
   // read-before-write at the same slot gives a delay of exactly i_len accepts
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         r_ptr  <= '0;
         r_dout <= '0;
      end else if (i_clr) begin
         r_ptr  <= '0;
      end else if (i_en) begin
         r_dout <= r_mem[r_ptr];
         r_ptr  <= w_wrap ? '0 : r_ptr + 1'b1;
      end
endmodule

// File: rtl/gauss3x3_stream.sv
// gauss3x3_stream: streaming 3x3 Gaussian smoother with two cascaded line buffers and self-flush.
// Define FILTER_ROUND_EN for round-half-up results; default truncates.
module gauss3x3_stream
   import gauss3x3_stream_pkg::*;
(
   input logic               i_clock,
   input logic               i_reset,
   gauss3x3_stream_if.slave  io_bus
);
   logic [2:0]             r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_w, r_n, r_in_cnt, r_sk, r_pos, r_out_cnt, r_col, r_row;
   logic                   r_degen;
   logic                   r_va, r_ba;
   stage_t                 r_sb;
   logic [PIXEL_WIDTH:0]   r_dout;
   logic [PIXEL_WIDTH-1:0] r_t0, r_t1, r_m0, r_m1, r_b0, r_b1, r_b2;
   logic [PIXEL_WIDTH-1:0] w_t2, w_m2, w_pix;
   logic [ADDR_WIDTH:0]    w_len1, w_len2;
   logic [SUM_WIDTH-1:0]   w_sum;
   logic                   w_real, w_bubble, w_acc, w_launch, w_border, w_last_col;
   logic [DATA_WIDTH-1:0]  w_in_nxt;
   assign w_real     = (r_state == ST_FILL || r_state == ST_RUN) && io_bus.data_in[PIXEL_WIDTH];
   assign w_bubble   = r_state == ST_FLUSH && r_pos < r_n;
   assign w_acc      = !io_bus.reflesh && (w_real || w_bubble);
   assign w_pix      = w_real ? io_bus.data_in[PIXEL_WIDTH-1:0] : '0;
   assign w_launch   = w_acc && r_sk >= r_w + 1'b1 && r_pos < r_n;
   assign w_last_col = r_col == r_w - 1'b1;
   assign w_border   = r_degen || r_row == '0 || r_col == '0 || w_last_col || r_pos >= r_n - r_w;
   assign w_in_nxt   = r_in_cnt + 1'b1;
   assign w_len1     = r_w[ADDR_WIDTH:0];
   assign w_len2     = w_len1 - 1'b1;
   // the second buffer is fed from the first one's registered output, one accept late, so it is one shorter
   gauss3x3_stream_line_buffer u_lb1 (
      .i_clock(i_clock), .i_reset(i_reset), .i_clr(io_bus.reflesh), .i_en(w_acc),
      .i_len(w_len1), .i_din(w_pix), .o_dout(w_m2));
   gauss3x3_stream_line_buffer u_lb2 (
      .i_clock(i_clock), .i_reset(i_reset), .i_clr(io_bus.reflesh), .i_en(w_acc),
      .i_len(w_len2), .i_din(w_m2), .o_dout(w_t2));
   assign w_sum = tap(K00, r_t0) + tap(K01, r_t1) + tap(K02, w_t2)
                + tap(K10, r_m0) + tap(K11, r_m1) + tap(K12, w_m2)
                + tap(K20, r_b0) + tap(K21, r_b1) + tap(K22, r_b2);
   assign w_state_nxt = (w_real && w_in_nxt == r_n) ? ST_FLUSH :
                        (w_real && r_state == ST_FILL && w_in_nxt == r_w + 1'b1) ? ST_RUN :
                        (r_state == ST_FLUSH && r_out_cnt == r_n) ? ST_DONE : r_state;
   always_ff @(posedge i_clock)
      if (w_acc) begin
         r_b2 <= w_pix;
         r_b1 <= r_b2;
         r_b0 <= r_b1;
         r_m1 <= w_m2;
         r_m0 <= r_m1;
         r_t1 <= w_t2;
         r_t0 <= r_t1;
      end
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_w       <= '0;
         r_n       <= '0;
         r_degen   <= 1'b0;
         r_in_cnt  <= '0;
         r_sk      <= '0;
         r_pos     <= '0;
         r_out_cnt <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_va      <= 1'b0;
         r_ba      <= 1'b0;
         r_sb      <= '0;
         r_dout    <= '0;
      end else if (io_bus.reflesh) begin
         r_state   <= ST_FILL;
         r_w       <= io_bus.image_width;
         r_n       <= io_bus.image_size;
         r_degen   <= io_bus.image_width < 3 || io_bus.image_size < io_bus.image_width * DATA_WIDTH'(3);
         r_in_cnt  <= '0;
         r_sk      <= '0;
         r_pos     <= '0;
         r_out_cnt <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_va      <= 1'b0;
         r_ba      <= 1'b0;
         r_sb      <= '0;
         r_dout    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_real && r_in_cnt != r_n) r_in_cnt <= w_in_nxt;
         if (w_acc) r_sk <= r_sk + 1'b1;
         if (w_launch) begin
            r_pos <= r_pos + 1'b1;
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            r_row <= w_last_col ? r_row + 1'b1 : r_row;
         end
         r_va   <= w_launch;
         r_ba   <= w_border;
         r_sb   <= '{vld: r_va, brd: r_ba, ctr: r_m1, sum: w_sum};
         r_dout <= r_sb.vld ? {1'b1, r_sb.brd ? r_sb.ctr : scale(r_sb.sum)} : {1'b0, r_dout[PIXEL_WIDTH-1:0]};
         if (r_sb.vld) r_out_cnt <= r_out_cnt + 1'b1;
      end
   assign io_bus.data_out = r_dout;
   assign io_bus.busy     = r_state == ST_FILL || r_state == ST_RUN || r_state == ST_FLUSH;
   assign io_bus.done     = r_state == ST_DONE;
endmodule

// File: tb/tb_gauss3x3_stream.sv
// tb_gauss3x3_stream: randomized scoreboard bench for gauss3x3_stream against a 2-D reference model.
module tb_gauss3x3_stream;
   import gauss3x3_stream_pkg::*;
   logic clk = 1'b0;
   logic rst;
   int   pix [1024];
   int   exp_q [$];
   int   n_vec = 0;
   int   n_bad = 0;
   gauss3x3_stream_if bus();
   gauss3x3_stream dut (.i_clock(clk), .i_reset(rst), .io_bus(bus));
   always #5 clk = ~clk;
   task automatic check(string nm, int act, int req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, req);
      end
   endtask
   always @(negedge clk)
      if (bus.data_out[8] === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output got=%0d want=none", bus.data_out[7:0]);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(bus.data_out[7:0]) != e) begin
               n_bad++;
               $display("FAIL pixel_out got=%0d want=%0d", bus.data_out[7:0], e);
            end
         end
      end
   function automatic void push_expected(int w, int n);
      for (int p = 0; p < n; p++) begin
         int r, c, s, e;
         r = p / w;
         c = p % w;
         if (w < 3 || n < 3 * w || r == 0 || r == n / w - 1 || c == 0 || c == w - 1) e = pix[p];
         else begin
            s = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  s += (2 - dr * dr) * (2 - dc * dc) * pix[(r + dr) * w + c + dc];
`ifdef FILTER_ROUND_EN
            e = (s + 8) / 16;
`else
            e = s / 16;
`endif
         end
         exp_q.push_back(e);
      end
   endfunction
   task automatic start(int w, int n);
      bus.image_width = w;
      bus.image_size  = n;
      bus.data_in     = '0;
      bus.reflesh     = 1'b1;
      @(posedge clk); #1;
      bus.reflesh = 1'b0;
      exp_q.delete();
      check("busy_after_reflesh", int'(bus.busy), 1);
      check("done_after_reflesh", int'(bus.done), 0);
   endtask
   task automatic feed(int cnt, int mode);
      int   i, ph;
      logic v;
      logic [7:0] px;
      i  = 0;
      ph = 1;
      while (i < cnt) begin
         v  = mode == 0 ? 1'b1 : mode == 1 ? ph[0] : 1'($urandom_range(0, 1));
         ph = 1 - ph;
         px = pix[i][7:0];
         bus.data_in = {v, px};
         @(posedge clk); #1;
         if (v) i++;
      end
      bus.data_in = '0;
   endtask
   task automatic wait_done(string nm);
      int c;
      c = 0;
      while (bus.done !== 1'b1 && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      check({nm, "_done"}, int'(bus.done), 1);
      check({nm, "_busy"}, int'(bus.busy), 0);
      check({nm, "_outputs_left"}, exp_q.size(), 0);
   endtask
   task automatic run_frame(string nm, int w, int n, int mode);
      start(w, n);
      push_expected(w, n);
      feed(n, mode);
      wait_done(nm);
   endtask
   task automatic fill_rand(int n);
      for (int i = 0; i < n; i++) pix[i] = int'($urandom_range(0, 255));
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      bus.reflesh = 1'b0;
      bus.image_width = '0;
      bus.image_size = '0;
      bus.data_in = '0;
      #12;
      check("reset_data_out", int'(bus.data_out), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) pix[i] = 77;
      feed(4, 0);
      check("idle_ignores_input", int'(bus.busy), 0);
      for (int i = 0; i < 16; i++) pix[i] = 100;
      run_frame("flat", 4, 16, 0);
      feed(3, 0);
      check("done_held", int'(bus.done), 1);
      for (int i = 0; i < 25; i++) pix[i] = 0;
      pix[12] = 160;
      run_frame("impulse", 5, 25, 0);
      for (int i = 0; i < 9; i++) pix[i] = 0;
      pix[4] = 255;
      run_frame("rounding", 3, 9, 0);
      for (int i = 0; i < 32; i++) pix[i] = i * 8;
      run_frame("ramp", 8, 32, 0);
      run_frame("ramp_gaps", 8, 32, 1);
      fill_rand(16);
      start(4, 16);
      push_expected(4, 16);
      feed(10, 0);
      fill_rand(16);
      run_frame("restart", 4, 16, 2);
      fill_rand(8);
      run_frame("degen_w2", 2, 8, 2);
      fill_rand(12);
      run_frame("degen_h2", 6, 12, 0);
      for (int f = 0; f < 6; f++) begin
         int w, h;
         w = int'($urandom_range(3, 12));
         h = int'($urandom_range(3, 8));
         fill_rand(w * h);
         run_frame("random", w, h * w, 2);
      end
      fill_rand(256);
      run_frame("wide", 64, 256, 2);
      for (int i = 0; i < 16; i++) pix[i] = 100;
      start(4, 16);
      push_expected(4, 16);
      feed(16, 0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_rst_data_out", int'(bus.data_out), 0);
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_done", int'(bus.done), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      feed(4, 0);
      repeat (4) @(posedge clk);
      #1;
      check("idle_after_rst", int'(bus.busy), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
